vec_load_unpack: RTL and testbench

// - Vector load path: reads LANES consecutive LANE_W-bit words from sample RAM and assembles them into a lane array.
// - Also presents the same data as one flat vector; lane k occupies bits [k*LANE_W +: LANE_W], lane 0 in the LSBs.
// - Sits between the data RAM (1-cycle synchronous read) and the vector register file / SIMD ALU operand inputs.
// - Inverse of the lane-to-flat-vector packing on the ALU write-back path.

---
 rtl/vec_load_unpack.sv | 145 ++++++++++++++
 tb/tb_vec_load_unpack.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/vec_load_unpack.sv
// vec_load_unpack: reads LANES consecutive RAM words into a lane array.
// Optional stride port enabled by macro VLOAD_STRIDE_EN.
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   start            load request (sampled in IDLE only)
//   base_addr        word address of lane 0, captured with start
//   stride           word stride, captured with start (VLOAD_STRIDE_EN only)
//   mem_rd_en        RAM read enable
//   mem_addr         RAM word address (holds when mem_rd_en=0)
//   mem_rdata        RAM read data, valid one cycle after mem_rd_en
//   lanes_out        assembled lanes, registered
//   bits_out         flat view of lanes_out, lane 0 in the LSBs
//   busy             high in READ, DRAIN and DONE
//   done             one-cycle pulse when lanes_out is complete
module vec_load_unpack #(
    parameter int LANES  = 16,
    parameter int LANE_W = 32,
    parameter int ADDR_W = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [ADDR_W-1:0]             base_addr,
`ifdef VLOAD_STRIDE_EN
    input  logic [ADDR_W-1:0]             stride,
`endif
    output logic                          mem_rd_en,
    output logic [ADDR_W-1:0]             mem_addr,
    input  logic [LANE_W-1:0]             mem_rdata,
    output logic [LANES-1:0][LANE_W-1:0]  lanes_out,
    output logic [LANES*LANE_W-1:0]       bits_out,
    output logic                          busy,
    output logic                          done
);

    localparam int CNT_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(LANES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                         r_state;
    logic [CNT_W-1:0]               r_rd_cnt;
    logic [CNT_W-1:0]               r_wr_cnt;
    logic                           r_cap_vld;
    logic                           r_rd_en;
    logic [ADDR_W-1:0]              r_addr;
    logic [LANES-1:0][LANE_W-1:0]   r_lanes;
    logic                           r_busy;
    logic                           r_done;
    logic [ADDR_W-1:0]              w_stride;

`ifdef VLOAD_STRIDE_EN
    logic [ADDR_W-1:0]              r_stride;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stride <= '0;
        end else if (r_state == S_IDLE && start) begin
            r_stride <= stride;
        end
    end

    assign w_stride = r_stride;
`else
    assign w_stride = ADDR_W'(1);
`endif

    // Address is advanced incrementally: base + k*stride, wrapping
    // naturally at the ADDR_W boundary.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_rd_cnt <= '0;
            r_rd_en  <= 1'b0;
            r_addr   <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state  <= S_READ;
                        r_rd_cnt <= '0;
                        r_rd_en  <= 1'b1;
                        r_addr   <= base_addr;
                        r_busy   <= 1'b1;
                    end
                end
                S_READ: begin
                    if (r_rd_cnt == LAST) begin
                        r_state <= S_DRAIN;
                        r_rd_en <= 1'b0;
                    end else begin
                        r_rd_cnt <= r_rd_cnt + CNT_W'(1);
                        r_addr   <= r_addr + w_stride;
                    end
                end
                S_DRAIN: begin
                    r_state <= S_DONE;
                    r_done  <= 1'b1;
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Capture side trails the read side by one cycle. Clearing r_cap_vld
    // on reset drops the response to a read issued just before reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cap_vld <= 1'b0;
            r_wr_cnt  <= '0;
            r_lanes   <= '0;
        end else begin
            r_cap_vld <= r_rd_en;
            if (r_state == S_IDLE && start) begin
                r_wr_cnt <= '0;
            end else if (r_cap_vld) begin
                r_lanes[r_wr_cnt] <= mem_rdata;
                r_wr_cnt          <= r_wr_cnt + CNT_W'(1);
            end
        end
    end

    assign mem_rd_en = r_rd_en;
    assign mem_addr  = r_addr;
    assign lanes_out = r_lanes;
    assign bits_out  = r_lanes;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

// File: tb/tb_vec_load_unpack.sv
// tb_vec_load_unpack: directed table-driven bench for vec_load_unpack.
// RAM model returns word w = w*3+1 one cycle after a read.
module tb_vec_load_unpack;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  start;
    logic [15:0]           base_addr;
`ifdef VLOAD_STRIDE_EN
    logic [15:0]           stride;
`endif
    logic                  mem_rd_en;
    logic [15:0]           mem_addr;
    logic [31:0]           mem_rdata = 32'd0;
    logic [15:0][31:0]     lanes_out;
    logic [511:0]          bits_out;
    logic                  busy;
    logic                  done;

    int n_err = 0;
    int n_chk = 0;

    vec_load_unpack dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
`ifdef VLOAD_STRIDE_EN
        .stride    (stride),
`endif
        .mem_rd_en (mem_rd_en),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .lanes_out (lanes_out),
        .bits_out  (bits_out),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ram(input logic [15:0] a);
        return {16'd0, a} * 32'd3 + 32'd1;
    endfunction

    always @(posedge clk) begin
        if (mem_rd_en) mem_rdata <= ram(mem_addr);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Start in cycle 0; verify one read per cycle in cycles 1..16 and
    // return the cycle in which done is seen (-1 if never).
    task automatic run_load(input logic [15:0] base, input logic [15:0] strd,
                            output int dcyc);
        int          bad;
        logic [15:0] ea;
        bad  = 0;
        dcyc = -1;
        base_addr = base;
`ifdef VLOAD_STRIDE_EN
        stride = strd;
`endif
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            ea = base + strd * 16'(c - 1);
            if (c <= 16) begin
                if (!(mem_rd_en === 1'b1 && mem_addr === ea)) bad++;
            end else if (mem_rd_en !== 1'b0) begin
                bad++;
            end
            if (done === 1'b1) begin
                dcyc = c;
                break;
            end
            tick();
        end
        chk("addr_seq", 64'(bad), 64'd0);
    endtask

    typedef struct {
        logic [15:0] base;
        int          lane;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[6];

    initial begin
        int d;
        int bad;
        int dpulse;

        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int d;
        int bad;
        int dpulse;

        tbl[0] = '{16'h0010, 0,  32'h0000_0031};
        tbl[1] = '{16'h0010, 15, 32'h0000_005E};
        tbl[2] = '{16'hFFF8, 8,  32'h0000_0001};
        tbl[3] = '{16'hFFF8, 7,  32'h0002_FFFE};
        tbl[4] = '{16'hFFF8, 0,  32'h0002_FFE9};
        tbl[5] = '{16'h1234, 5,  32'h0000_36AC};

        // Reset with start asserted: nothing must be issued.
        rst       = 1'b1;
        start     = 1'b1;
        base_addr = 16'h0010;
`ifdef VLOAD_STRIDE_EN
        stride    = 16'd1;
`endif
        tick();
        tick();
        chk("rst_rd_en", 64'(mem_rd_en), 64'd0);
        chk("rst_addr",  64'(mem_addr),  64'd0);
        chk("rst_busy",  64'(busy),      64'd0);
        chk("rst_done",  64'(done),      64'd0);
        chk("rst_bits",  64'(bits_out != '0), 64'd0);
        rst   = 1'b0;
        start = 1'b0;
        tick();
        chk("post_rst_rd_en", 64'(mem_rd_en), 64'd0);
        tick();

        // Contiguous load, full lane check.
        run_load(16'h0010, 16'd1, d);
        chk("contig_done_cyc", 64'(d), 64'd18);
        chk("contig_busy_done", 64'(busy), 64'd1);
        bad = 0;
        for (int k = 0; k < 16; k++) begin
            if (lanes_out[k] !== 32'((16 + k) * 3 + 1)) bad++;
        end
        chk("contig_lanes", 64'(bad), 64'd0);
        chk("contig_bits_lo", 64'(bits_out[31:0]), 64'h31);
        chk("contig_bits_hi", 64'(bits_out[511:480]), 64'h5E);
        tick();
        chk("done_one_cycle", 64'(done), 64'd0);
        chk("idle_busy", 64'(busy), 64'd0);

        // Table of loads with single-lane expectations.
        for (int i = 0; i < 6; i++) begin
            run_load(tbl[i].base, 16'd1, d);
            chk($sformatf("tbl%0d_done_cyc", i), 64'(d), 64'd18);
            chk($sformatf("tbl%0d_lane", i),
                64'(lanes_out[tbl[i].lane]), 64'(tbl[i].exp));
            tick();
        end

        // start held high: pulses in cycles 5 and 18 ignored, next load
        // accepted in cycle 19 with first read in cycle 20.
        base_addr = 16'h0040;
        start     = 1'b1;
        tick();
        for (int c = 1; c <= 37; c++) begin
            if (c == 5)  chk("b2b_busy_c5", 64'(busy), 64'd1);
            if (c == 5)  chk("b2b_addr_c5", 64'(mem_addr), 64'h0044);
            if (c == 18) chk("b2b_done_c18", 64'(done), 64'd1);
            if (c == 19) chk("b2b_rd_c19", 64'(mem_rd_en), 64'd0);
            if (c == 19) chk("b2b_busy_c19", 64'(busy), 64'd0);
            if (c == 20) chk("b2b_rd_c20", 64'(mem_rd_en), 64'd1);
            if (c == 20) chk("b2b_addr_c20", 64'(mem_addr), 64'h0040);
            if (c == 36) chk("b2b_done_c36", 64'(done), 64'd0);
            if (c == 37) chk("b2b_done_c37", 64'(done), 64'd1);
            if (c < 37) tick();
        end
        start = 1'b0;
        tick();

        // Reset in cycle 9 of a load.
        base_addr = 16'h0200;
        start     = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c < 9; c++) tick();
        chk("mid_lane0", 64'(lanes_out[0]), 64'h601);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_busy",  64'(busy),      64'd0);
        chk("mid_rst_rd_en", 64'(mem_rd_en), 64'd0);
        chk("mid_rst_bits",  64'(bits_out != '0), 64'd0);
        dpulse = 0;
        bad    = 0;
        for (int c = 0; c < 30; c++) begin
            tick();
            if (done === 1'b1) dpulse++;
            if (bits_out !== '0) bad++;
            if (mem_rd_en !== 1'b0) bad++;
        end
        chk("mid_no_done", 64'(dpulse), 64'd0);
        chk("mid_quiet", 64'(bad), 64'd0);
        run_load(16'h0300, 16'd1, d);
        chk("post_mid_done_cyc", 64'(d), 64'd18);
        chk("post_mid_lane2", 64'(lanes_out[2]), 64'h907);
        tick();

`ifdef VLOAD_STRIDE_EN
        run_load(16'h0100, 16'd4, d);
        chk("stride4_done_cyc", 64'(d), 64'd18);
        chk("stride4_lane3", 64'(lanes_out[3]), 64'h325);
        chk("stride4_lane15", 64'(lanes_out[15]), 64'h3B5);
        tick();
        run_load(16'h0100, 16'd0, d);
        chk("stride0_done_cyc", 64'(d), 64'd18);
        bad = 0;
        for (int k = 0; k < 16; k++) begin
            if (lanes_out[k] !== 32'h301) bad++;
        end
        chk("stride0_lanes", 64'(bad), 64'd0);
        tick();
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
